gps_sample_player: RTL

Replay counterpart to the GPS sample capture buffer. The host writes 16-bit words into a 64K-bit buffer, then the block streams them out one bit per sample strobe, LSB of each word first. A buffer filled by the capture path therefore replays in its original bit order. It sits between the host bus and the GPS correlator sample input, providing a deterministic recorded-signal source for bring-up and regression.

---
 rtl/gps_player_pkg.sv | 17 +
 rtl/player_ram.sv | 31 +++
 rtl/gps_sample_player.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gps_player_pkg.sv
// rtl/gps_player_pkg.sv - shared types and constants for the GPS sample player
//
// Holds the player state encoding and the word / bit-counter widths used by
// the top level and the bench.
package gps_player_pkg;

  localparam int WORD_BITS = 16;
  localparam int BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/player_ram.sv
// rtl/player_ram.sv - simple dual-port sample buffer with registered read
//
// Ports:
//   clk         sole clock
//   we          write enable
//   waddr/wdata write address / word
//   re          read enable
//   raddr       read address
//   rdata       read word, valid the cycle after re
module player_ram #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/gps_sample_player.sv
// rtl/gps_sample_player.sv - replays a host-loaded bit buffer one bit per strobe
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   wr, wdata    host word write at the write pointer (IDLE/DONE only)
//   wclr         return the write pointer to 0
//   len, loop    last word index and wrap enable, captured at start
//   start, stop  begin playback / abort to IDLE (stop has priority)
//   ce           sample strobe, consumes one bit while playing
//   dout         current sample bit (LSB of each word first)
//   dout_vld     high while playing
//   busy         high while priming or playing
//   done         high after a non-looping play has finished
import gps_player_pkg::*;

module gps_sample_player #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic                 wclr,
  input  logic [ADDR_BITS-1:0] len,
  input  logic                 loop,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 ce,
  output logic                 dout,
  output logic                 dout_vld,
  output logic                 busy,
  output logic                 done
);

  state_t                 state;
  logic                   prime_2;
  logic [ADDR_BITS-1:0]   wptr;
  logic [ADDR_BITS-1:0]   widx;
  logic [ADDR_BITS-1:0]   widx_nxt;
  logic [ADDR_BITS-1:0]   len_q;
  logic                   loop_q;
  logic [BIT_CNT_W-1:0]   bitcnt;
  logic [WORD_BITS-1:0]   shift;
  logic [WORD_BITS-1:0]   prefetch;
  logic                   pf_pend;
  logic                   wr_ok;
  logic [ADDR_BITS-1:0]   waddr;
  logic                   re;
  logic [ADDR_BITS-1:0]   raddr;
  logic [WORD_BITS-1:0]   rdata;
  logic                   word_end;
  logic                   last_word;

  function automatic logic [ADDR_BITS-1:0] next_idx(input logic [ADDR_BITS-1:0] idx,
                                                     input logic [ADDR_BITS-1:0] last);
    return (idx == last) ? '0 : idx + 1'b1;
  endfunction

  // Host write port; wclr forces this cycle's write to address 0.
  assign wr_ok = wr && (state == ST_IDLE || state == ST_DONE);
  assign waddr = wclr ? '0 : wptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wptr <= '0;
    else if (wclr)
      wptr <= {{(ADDR_BITS-1){1'b0}}, wr_ok};
    else if (wr_ok)
      wptr <= wptr + 1'b1;
  end

  assign widx_nxt  = next_idx(widx, len_q);
  assign word_end  = (state == ST_PLAY) && ce && (bitcnt == BIT_CNT_W'(WORD_BITS - 1));
  assign last_word = (widx == len_q) && !loop_q;

  // Read issue: PRIME fetches word 0 then the word after it; in PLAY each
  // word boundary fetches the word after the one being loaded, which keeps
  // the prefetch a full word ahead of the shifter.
  always_comb begin
    re    = 1'b0;
    raddr = widx;
    if (state == ST_PRIME) begin
      re    = 1'b1;
      raddr = prime_2 ? widx_nxt : widx;
    end else if (word_end && !last_word) begin
      re    = 1'b1;
      raddr = next_idx(widx_nxt, len_q);
    end
  end

  player_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (WORD_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      prime_2  <= 1'b0;
      widx     <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      bitcnt   <= '0;
      shift    <= '0;
      prefetch <= '0;
      pf_pend  <= 1'b0;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (stop) begin
      state    <= ST_IDLE;
      prime_2  <= 1'b0;
      widx     <= '0;
      bitcnt   <= '0;
      shift    <= '0;
      pf_pend  <= 1'b0;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_PRIME;
            prime_2 <= 1'b0;
            len_q   <= len;
            loop_q  <= loop;
            widx    <= '0;
            bitcnt  <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_PRIME: begin
          if (!prime_2) begin
            prime_2 <= 1'b1;
          end else begin
            shift    <= rdata;
            pf_pend  <= 1'b1;
            state    <= ST_PLAY;
            dout_vld <= 1'b1;
          end
        end
        ST_PLAY: begin
          // Read data arrives the cycle after issue.
          if (pf_pend) begin
            prefetch <= rdata;
            pf_pend  <= 1'b0;
          end
          if (ce) begin
            bitcnt <= bitcnt + 1'b1;
            if (word_end) begin
              if (last_word) begin
                state    <= ST_DONE;
                shift    <= '0;
                dout_vld <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                shift   <= prefetch;
                widx    <= widx_nxt;
                pf_pend <= 1'b1;
              end
            end else begin
              shift <= shift >> 1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dout = shift[0];

endmodule
